glitch_sequencer: RTL and testbench
===================================

Name: glitch_sequencer

Overview:
Executes one glitch campaign from the configuration registers written over the UART command interface. On a start strobe it latches delay, width, pulse count, pulse spacing and reset length. It then optionally holds the target in reset, waits the programmed delay, and emits a train of glitch pulses. It sits between the UART command handler (pulse_en/reset_en strobes, config values) and the glitch output pin / target reset pin.

Parameters:
DELAY_W, 16, width of delay_i and delay counter
WIDTH_W, 8, width of width_i and pulse-high counter
COUNT_W, 8, width of num_pulses_i and pulse counter
SPACING_W, 16, width of spacing_i and gap counter
RSTLEN_W, 16, width of reset_length_i and reset counter
TARGET_RST_ACTIVE_LOW, 0, 1 = target_rst_o asserted low

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
pulse_en_i  input  1  start strobe: no target reset phase
reset_en_i  input  1  start strobe: reset phase, then glitches
abort_i  input  1  synchronous abort
delay_i  input  DELAY_W  cycles from end of reset phase (or start) to first glitch
width_i  input  WIDTH_W  glitch high time in cycles
num_pulses_i  input  COUNT_W  number of glitch pulses
spacing_i  input  SPACING_W  low cycles between consecutive pulses
reset_length_i  input  RSTLEN_W  target reset assertion cycles
glitch_o  output  1  glitch drive, registered, active high
target_rst_o  output  1  target reset drive, registered, polarity per parameter
busy_o  output  1  sequence in progress
done_o  output  1  one-cycle completion pulse
pulses_done_o  output  COUNT_W  glitch pulses completed in current/last run

Behaviour:
- Reset: glitch_o=0, target_rst_o=inactive level, busy_o=0, done_o=0, pulses_done_o=0, state IDLE.
- States: IDLE, RESET, DELAY, PULSE, SPACE, DONE.
- Start: sampled only in IDLE at edge T. reset_en_i takes priority over pulse_en_i when both are high. reset_en_i with reset_length_i=0 behaves as pulse_en_i. All config inputs are latched at T; later input changes do not affect the run. pulses_done_o clears at T.
- Start strobes while busy are ignored.
- Timing, with R = latched reset_length (0 for pulse_en_i), D = delay, W = width, N = num_pulses, S = spacing:
  - busy_o is high from T+1 through the last active cycle.
  - target_rst_o is asserted for cycles T+1 .. T+R.
  - Pulse k (k = 0..N-1) drives glitch_o high for cycles P_k .. P_k+W-1, where P_k = T+1+R+D+k*(W+S).
  - No trailing gap after the last pulse.
- Completion: done_o is high for exactly one cycle at T+1+R+D+N*W+(N-1)*S. busy_o is low in that same cycle. The machine returns to IDLE the next cycle.
- pulses_done_o increments on the last high cycle of each pulse and holds its value after done.
- D=0: first glitch cycle at T+1+R.
- S=0: pulses merge, so glitch_o stays continuously high for N*W cycles. pulses_done_o still counts N.
- N=0 or W=0: no glitch is emitted. done_o fires at T+1+R+D.
- Counters saturate-free. Each phase counter loads value-1 and counts down to 0, so max values (e.g. 16'hFFFF) give exact lengths.
- abort_i (any state other than IDLE): the next cycle has glitch_o=0, target_rst_o inactive, busy_o=0, state IDLE, no done_o. pulses_done_o keeps its partial count. abort_i in IDLE has no effect.
- abort_i and a start strobe in the same IDLE cycle: the start is accepted.
- rst mid-run takes effect at the next edge, with all outputs at reset values.

Test Plan:
- delay=3, width=2, num=2, spacing=4, pulse_en at T=10 -> glitch_o high at cycles 14-15 and 20-21, done_o at 22, pulses_done_o=2, busy_o high 11-21.
- reset_en, reset_length=5, delay=0, width=1, num=1, T=10 -> target_rst_o asserted 11-15, glitch_o at 16, done_o at 17. Repeat with TARGET_RST_ACTIVE_LOW=1 -> inverted polarity.
- width=2, num=3, spacing=0, delay=0, T=10 -> glitch_o continuously high 11-16, done_o at 17, pulses_done_o=3.
- width=0, num=3, delay=2, T=10 -> glitch_o never high, done_o at 13, pulses_done_o=0.
- Run with delay=100, width=10, num=5, spacing=10. Assert pulse_en and reset_en mid-run -> both ignored. Assert abort_i during the 2nd pulse -> outputs idle next cycle, no done_o, pulses_done_o=1. A new start then runs normally.
- Change delay_i/width_i during an active run -> timing matches the values latched at start.

Source files
------------

// File: rtl/glitch_sequencer.sv
// glitch_sequencer: runs one glitch campaign (optional target reset, delay,
// then a train of glitch pulses) from configuration latched on a start strobe.
module glitch_sequencer #(
    parameter int DELAY_W               = 16,
    parameter int WIDTH_W               = 8,
    parameter int COUNT_W               = 8,
    parameter int SPACING_W             = 16,
    parameter int RSTLEN_W              = 16,
    parameter int TARGET_RST_ACTIVE_LOW = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pulse_en_i,
    input  logic                 reset_en_i,
    input  logic                 abort_i,
    input  logic [DELAY_W-1:0]   delay_i,
    input  logic [WIDTH_W-1:0]   width_i,
    input  logic [COUNT_W-1:0]   num_pulses_i,
    input  logic [SPACING_W-1:0] spacing_i,
    input  logic [RSTLEN_W-1:0]  reset_length_i,
    output logic                 glitch_o,
    output logic                 target_rst_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [COUNT_W-1:0]   pulses_done_o
);

    // One shared phase counter, wide enough for the longest phase.
    localparam int CNT_W_A = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;
    localparam int CNT_W_B = (SPACING_W > RSTLEN_W) ? SPACING_W : RSTLEN_W;
    localparam int CNT_W   = (CNT_W_A > CNT_W_B) ? CNT_W_A : CNT_W_B;

    // Idle (deasserted) level of the target reset pin.
    localparam logic TRST_IDLE = (TARGET_RST_ACTIVE_LOW != 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RESET = 3'd1,
        S_DELAY = 3'd2,
        S_PULSE = 3'd3,
        S_SPACE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [COUNT_W-1:0]   left_q, left_d;
    logic [DELAY_W-1:0]   delay_q, delay_d;
    logic [WIDTH_W-1:0]   width_q, width_d;
    logic [SPACING_W-1:0] spacing_q, spacing_d;
    logic [COUNT_W-1:0]   pulses_done_q, pulses_done_d;
    logic                 glitch_q, glitch_d;
    logic                 trst_q, trst_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // In IDLE the phase after reset is decided from the live inputs (they are
    // being latched on this very edge); afterwards from the latched copies.
    logic [DELAY_W-1:0]   sel_delay;
    logic [WIDTH_W-1:0]   sel_width;
    logic [COUNT_W-1:0]   sel_num;
    state_t               after_rst_state;
    logic [CNT_W-1:0]     after_rst_cnt;
    logic                 pulses_wanted_q;
    logic                 start;

    assign start     = pulse_en_i | reset_en_i;
    assign sel_delay = (state_q == S_IDLE) ? delay_i      : delay_q;
    assign sel_width = (state_q == S_IDLE) ? width_i      : width_q;
    assign sel_num   = (state_q == S_IDLE) ? num_pulses_i : left_q;

    assign after_rst_state = (sel_delay != '0) ? S_DELAY :
                             ((sel_width != '0) && (sel_num != '0)) ? S_PULSE : S_DONE;
    assign after_rst_cnt   = (sel_delay != '0) ? (CNT_W'(sel_delay) - CNT_W'(1)) :
                                                 (CNT_W'(sel_width) - CNT_W'(1));

    // A zero width or zero count means the pulse train is skipped entirely.
    assign pulses_wanted_q = (width_q != '0) && (left_q != '0);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            left_q        <= '0;
            delay_q       <= '0;
            width_q       <= '0;
            spacing_q     <= '0;
            pulses_done_q <= '0;
            glitch_q      <= 1'b0;
            trst_q        <= TRST_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            left_q        <= left_d;
            delay_q       <= delay_d;
            width_q       <= width_d;
            spacing_q     <= spacing_d;
            pulses_done_q <= pulses_done_d;
            glitch_q      <= glitch_d;
            trst_q        <= trst_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // Next-state and counter logic; each phase loads length-1 and counts to 0.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        left_d        = left_q;
        delay_d       = delay_q;
        width_d       = width_q;
        spacing_d     = spacing_q;
        pulses_done_d = pulses_done_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    delay_d       = delay_i;
                    width_d       = width_i;
                    spacing_d     = spacing_i;
                    left_d        = num_pulses_i;
                    pulses_done_d = '0;
                    if (reset_en_i && (reset_length_i != '0)) begin
                        state_d = S_RESET;
                        cnt_d   = CNT_W'(reset_length_i) - CNT_W'(1);
                    end else begin
                        state_d = after_rst_state;
                        cnt_d   = after_rst_cnt;
                    end
                end
            end
            S_RESET: begin
                if (cnt_q == '0) begin
                    state_d = after_rst_state;
                    cnt_d   = after_rst_cnt;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DELAY: begin
                if (cnt_q == '0) begin
                    state_d = pulses_wanted_q ? S_PULSE : S_DONE;
                    cnt_d   = CNT_W'(width_q) - CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    pulses_done_d = pulses_done_q + COUNT_W'(1);
                    if (left_q > COUNT_W'(1)) begin
                        left_d = left_q - COUNT_W'(1);
                        // Zero spacing chains pulses back to back (merged high).
                        if (spacing_q != '0) begin
                            state_d = S_SPACE;
                            cnt_d   = CNT_W'(spacing_q) - CNT_W'(1);
                        end else begin
                            state_d = S_PULSE;
                            cnt_d   = CNT_W'(width_q) - CNT_W'(1);
                        end
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SPACE: begin
                if (cnt_q == '0) begin
                    state_d = S_PULSE;
                    cnt_d   = CNT_W'(width_q) - CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort drops straight to IDLE and keeps the partial pulse count.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d       = S_IDLE;
            pulses_done_d = pulses_done_q;
        end
    end

    // Output decode from the next state, so every pin comes straight off a flop.
    always_comb begin
        glitch_d = (state_d == S_PULSE);
        trst_d   = (state_d == S_RESET) ? ~TRST_IDLE : TRST_IDLE;
        busy_d   = (state_d == S_RESET) || (state_d == S_DELAY) ||
                   (state_d == S_PULSE) || (state_d == S_SPACE);
        done_d   = (state_d == S_DONE);
    end

    assign glitch_o      = glitch_q;
    assign target_rst_o  = trst_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign pulses_done_o = pulses_done_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// tb_glitch_sequencer: scoreboard bench for glitch_sequencer. The driver pushes
// one run descriptor per accepted start; the monitor predicts every output each
// cycle from closed-form timing formulas and compares both polarity variants.
module tb_glitch_sequencer;

    localparam int DELAY_W   = 16;
    localparam int WIDTH_W   = 8;
    localparam int COUNT_W   = 8;
    localparam int SPACING_W = 16;
    localparam int RSTLEN_W  = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 pulse_en_i = 1'b0;
    logic                 reset_en_i = 1'b0;
    logic                 abort_i = 1'b0;
    logic [DELAY_W-1:0]   delay_i = '0;
    logic [WIDTH_W-1:0]   width_i = '0;
    logic [COUNT_W-1:0]   num_pulses_i = '0;
    logic [SPACING_W-1:0] spacing_i = '0;
    logic [RSTLEN_W-1:0]  reset_length_i = '0;

    logic               glitch_hi, trst_hi, busy_hi, done_hi;
    logic [COUNT_W-1:0] pd_hi;
    logic               glitch_lo, trst_lo, busy_lo, done_lo;
    logic [COUNT_W-1:0] pd_lo;

    glitch_sequencer #(
        .DELAY_W(DELAY_W), .WIDTH_W(WIDTH_W), .COUNT_W(COUNT_W),
        .SPACING_W(SPACING_W), .RSTLEN_W(RSTLEN_W), .TARGET_RST_ACTIVE_LOW(0)
    ) u_dut_hi (
        .clk(clk), .rst(rst), .pulse_en_i(pulse_en_i), .reset_en_i(reset_en_i),
        .abort_i(abort_i), .delay_i(delay_i), .width_i(width_i),
        .num_pulses_i(num_pulses_i), .spacing_i(spacing_i),
        .reset_length_i(reset_length_i), .glitch_o(glitch_hi),
        .target_rst_o(trst_hi), .busy_o(busy_hi), .done_o(done_hi),
        .pulses_done_o(pd_hi)
    );

    glitch_sequencer #(
        .DELAY_W(DELAY_W), .WIDTH_W(WIDTH_W), .COUNT_W(COUNT_W),
        .SPACING_W(SPACING_W), .RSTLEN_W(RSTLEN_W), .TARGET_RST_ACTIVE_LOW(1)
    ) u_dut_lo (
        .clk(clk), .rst(rst), .pulse_en_i(pulse_en_i), .reset_en_i(reset_en_i),
        .abort_i(abort_i), .delay_i(delay_i), .width_i(width_i),
        .num_pulses_i(num_pulses_i), .spacing_i(spacing_i),
        .reset_length_i(reset_length_i), .glitch_o(glitch_lo),
        .target_rst_o(trst_lo), .busy_o(busy_lo), .done_o(done_lo),
        .pulses_done_o(pd_lo)
    );

    always #5 clk = ~clk;

    // One accepted run: start cycle T and the latched R, D, W, N, S.
    typedef struct {
        int t;
        int rl;
        int dl;
        int wd;
        int np;
        int sp;
    } run_t;

    run_t sb[$];
    int   vectors = 0;
    int   misc    = 0;
    int   cyc     = 0;
    int   last_pd = 0;
    logic rst_s   = 1'b1;
    logic abort_s = 1'b0;

    // Cycle numbering: the value after posedge k is "cycle k"; inputs seen at
    // that edge were the ones driven during the previous cycle.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rst_s   <= rst;
        abort_s <= abort_i;
    end

    function automatic int end_cycle(run_t r);
        int body;
        body = 0;
        if (r.np > 0 && r.wd > 0) body = r.np * r.wd + (r.np - 1) * r.sp;
        return r.t + 1 + r.rl + r.dl + body;
    endfunction

    function automatic int glitch_at(run_t r, int c);
        int off;
        off = c - (r.t + 1 + r.rl + r.dl);
        if (r.np == 0 || r.wd == 0 || off < 0) return 0;
        return ((off / (r.wd + r.sp) < r.np) && (off % (r.wd + r.sp) < r.wd)) ? 1 : 0;
    endfunction

    // Pulses whose last high cycle lies strictly before cycle c.
    function automatic int pd_at(run_t r, int c);
        int last0;
        int k;
        last0 = r.t + r.rl + r.dl + r.wd;
        if (r.np == 0 || r.wd == 0 || c <= last0) return 0;
        k = (c - 1 - last0) / (r.wd + r.sp) + 1;
        return (k > r.np) ? r.np : k;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            misc++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic check_all(input int g, input int tr, input int b, input int d, input int p);
        check("glitch_hi", int'(glitch_hi), g);
        check("glitch_lo", int'(glitch_lo), g);
        check("trst_hi",   int'(trst_hi), tr);
        check("trst_lo",   int'(trst_lo), 1 - tr);
        check("busy_hi",   int'(busy_hi), b);
        check("busy_lo",   int'(busy_lo), b);
        check("done_hi",   int'(done_hi), d);
        check("done_lo",   int'(done_lo), d);
        check("pd_hi",     int'(pd_hi), p);
        check("pd_lo",     int'(pd_lo), p);
    endtask

    // Monitor: predict this cycle's outputs from the head run and compare.
    always @(negedge clk) begin
        int   c;
        int   e;
        run_t r;
        c = cyc;
        if (rst_s) begin
            sb.delete();
            last_pd = 0;
            check_all(0, 0, 0, 0, 0);
        end else if (sb.size() == 0 || c <= sb[0].t) begin
            check_all(0, 0, 0, 0, last_pd);
        end else begin
            r = sb[0];
            e = end_cycle(r);
            if (abort_s && (c - 1 >= r.t + 1) && (c - 1 < e)) begin
                last_pd = pd_at(r, c - 1);
                check_all(0, 0, 0, 0, last_pd);
                $display("run T=%0d aborted at cycle %0d, pulses_done=%0d", r.t, c - 1, last_pd);
                void'(sb.pop_front());
            end else begin
                check_all(glitch_at(r, c), (c <= r.t + r.rl) ? 1 : 0,
                          (c < e) ? 1 : 0, (c == e) ? 1 : 0, pd_at(r, c));
                if (c >= e) begin
                    last_pd = pd_at(r, c);
                    $display("run T=%0d R=%0d D=%0d W=%0d N=%0d S=%0d done at cycle %0d",
                             r.t, r.rl, r.dl, r.wd, r.np, r.sp, e);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 = pulse_en, 1 = reset_en, 2 = both. abort_off: -1 none,
    // -2 random, else cycle offset from T at which abort_i is driven.
    task automatic do_run(input int kind, input int rl, input int dl, input int wd,
                          input int np, input int sp, input int abort_off,
                          input bit mid_start, input bit abort_at_start);
        run_t rec;
        int   e;
        int   stop;
        int   mid;
        int   ab;
        delay_i        = DELAY_W'(dl);
        width_i        = WIDTH_W'(wd);
        num_pulses_i   = COUNT_W'(np);
        spacing_i      = SPACING_W'(sp);
        reset_length_i = RSTLEN_W'(rl);
        pulse_en_i     = (kind != 1);
        reset_en_i     = (kind != 0);
        abort_i        = abort_at_start;
        rec.t  = cyc;
        rec.rl = (kind != 0) ? rl : 0;
        rec.dl = dl;
        rec.wd = wd;
        rec.np = np;
        rec.sp = sp;
        sb.push_back(rec);
        e  = end_cycle(rec);
        ab = abort_off;
        if (ab == -2) begin
            ab = -1;
            if ((e - rec.t) >= 2 && $urandom_range(0, 3) == 0)
                ab = $urandom_range(1, e - rec.t - 1);
        end
        stop = (ab > 0) ? rec.t + ab : e;
        mid  = rec.t + 1 + (stop - rec.t - 1) / 2;
        while (cyc < stop + 1) begin
            next_cycle();
            pulse_en_i     = 1'b0;
            reset_en_i     = 1'b0;
            abort_i        = 1'b0;
            // Config changes mid-run must not affect the latched timing.
            delay_i        = DELAY_W'($urandom);
            width_i        = WIDTH_W'($urandom);
            num_pulses_i   = COUNT_W'($urandom);
            spacing_i      = SPACING_W'($urandom);
            reset_length_i = RSTLEN_W'($urandom);
            if (ab > 0 && cyc == stop) abort_i = 1'b1;
            if (mid_start && cyc == mid && cyc < stop) begin
                pulse_en_i = 1'b1;
                reset_en_i = 1'b1;
            end
        end
    endtask

    initial begin
        repeat (3) next_cycle();
        rst = 1'b0;
        repeat (2) next_cycle();

        do_run(0, 0, 3, 2, 2, 4, -1, 1'b0, 1'b0);
        do_run(1, 5, 0, 1, 1, 0, -1, 1'b0, 1'b0);
        do_run(0, 0, 0, 2, 3, 0, -1, 1'b0, 1'b0);
        do_run(0, 0, 2, 0, 3, 1, -1, 1'b0, 1'b0);
        // Abort in the 2nd pulse: P1 = T+1+100+20, abort at offset 4 into it.
        do_run(0, 0, 100, 10, 5, 10, 125, 1'b1, 1'b0);
        do_run(2, 4, 5, 3, 2, 1, -1, 1'b1, 1'b0);
        do_run(1, 0, 2, 1, 2, 1, -1, 1'b0, 1'b0);
        do_run(0, 0, 2, 2, 2, 2, -1, 1'b0, 1'b1);
        do_run(0, 0, 0, 3, 0, 1, -1, 1'b0, 1'b0);
        do_run(0, 7, 0, 1, 1, 0, -1, 1'b0, 1'b0);

        // Abort while idle has no effect.
        abort_i = 1'b1;
        next_cycle();
        abort_i = 1'b0;
        repeat (3) next_cycle();

        for (int i = 0; i < 40; i++) begin
            do_run($urandom_range(0, 2), $urandom_range(0, 6), $urandom_range(0, 12),
                   $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
                   -2, $urandom_range(0, 1) == 1, 1'b0);
            for (int g = $urandom_range(0, 2); g > 0; g--) next_cycle();
        end

        // Reset in the middle of a run returns everything to reset values.
        delay_i      = DELAY_W'(4);
        width_i      = WIDTH_W'(3);
        num_pulses_i = COUNT_W'(4);
        spacing_i    = SPACING_W'(2);
        pulse_en_i   = 1'b1;
        begin
            run_t rr;
            rr.t = cyc; rr.rl = 0; rr.dl = 4; rr.wd = 3; rr.np = 4; rr.sp = 2;
            sb.push_back(rr);
        end
        next_cycle();
        pulse_en_i = 1'b0;
        repeat (9) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        repeat (2) next_cycle();

        do_run(1, 3, 1, 2, 2, 1, -1, 1'b0, 1'b0);
        repeat (3) next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
